// File: rtl/range_sweep_controller_pkg.sv
// Shared definitions for the range sweep controller: default legal counter
// range, default widths and the sweep state encoding.
package range_sweep_controller_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_MIN_VAL = 10;
  localparam int unsigned DEF_MAX_VAL = 40;
  localparam int unsigned DEF_SWP_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_UP,
    ST_DWELL_HI,
    ST_DOWN,
    ST_DWELL_LO
  } sweep_state_t;

endpackage

// File: rtl/range_sweep_controller_dwell_timer.sv
// sweep_dwell_timer: loadable down-counter that stops at zero.
// Used for the hold period at both sweep bounds.
//  clk, rst  clock, synchronous active-high reset
//  load      load load_val this cycle (takes priority over dec)
//  load_val  value to load
//  dec       decrement by one (saturates at zero)
//  expired   count is zero
module sweep_dwell_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/range_sweep_controller.sv
// range_sweep_controller: drives an up/down/load range counter through
// programmable triangle sweeps lo->hi->lo with a hold at each bound, and
// checks the counter's feedback against the expected value.
//  clk, rst    clock, synchronous active-high reset
//  start       1-cycle request; samples cfg_* when idle
//  stop        abort the sweep and park the counter
//  cfg_lo/hi   sweep bounds (MIN_VAL <= lo < hi <= MAX_VAL)
//  cfg_dwell   extra hold cycles at each bound
//  cfg_sweeps  number of full sweeps (0 = run until stop)
//  count       counter output (feedback)
//  u_d/load/data  counter controls
//  busy        sweep in progress
//  done        pulse when the programmed sweeps have finished
//  err         pulse on a rejected config or a feedback mismatch
module range_sweep_controller
  import range_sweep_controller_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MIN_VAL = DEF_MIN_VAL,
  parameter int unsigned MAX_VAL = DEF_MAX_VAL,
  parameter int unsigned SWP_W   = DEF_SWP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [7:0]       cfg_dwell,
  input  logic [SWP_W-1:0] cfg_sweeps,
  input  logic [WIDTH-1:0] count,
  output logic             u_d,
  output logic             load,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [SWP_W-1:0] ONE_SW = SWP_W'(1);

  sweep_state_t     state_q, state_n;
  logic [WIDTH-1:0] park_q, park_n, lo_q, lo_n, hi_q, hi_n, exp_q, data_n;
  logic [7:0]       dwell_q, dwell_n;
  logic [SWP_W-1:0] rem_q, rem_n;
  logic             cont_q, cont_n;
  logic             u_d_n, load_n, busy_n, done_n, err_n;
  logic             tmr_load, tmr_dec, tmr_expired, sweep_end, cfg_ok;
  logic [WIDTH-1:0] count_clamped;

  assign cfg_ok = (cfg_lo >= MIN_V) && (cfg_lo < cfg_hi) && (cfg_hi <= MAX_V);
  assign count_clamped = (count < MIN_V) ? MIN_V : ((count > MAX_V) ? MAX_V : count);

  sweep_dwell_timer #(.W(8)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (dwell_q - 8'd1),
    .dec      (tmr_dec),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_n   = state_q;
    park_n    = park_q;
    lo_n      = lo_q;
    hi_n      = hi_q;
    dwell_n   = dwell_q;
    rem_n     = rem_q;
    cont_n    = cont_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    sweep_end = 1'b0;

    if (state_q == ST_IDLE) begin
      if (start && !stop) begin
        if (cfg_ok) begin
          state_n = ST_LOAD;
          lo_n    = cfg_lo;
          hi_n    = cfg_hi;
          dwell_n = cfg_dwell;
          rem_n   = cfg_sweeps;
          cont_n  = (cfg_sweeps == '0);
        end else begin
          err_n = 1'b1;
        end
      end
    end else if (stop) begin
      state_n = ST_IDLE;
      park_n  = count_clamped;
    end else if ((state_q != ST_LOAD) && (count != exp_q)) begin
      state_n = ST_IDLE;
      park_n  = MIN_V;
      err_n   = 1'b1;
    end else begin
      // Bound tests fire one cycle early because the counter moves on the
      // same edge that the registered controls change.
      case (state_q)
        ST_LOAD: state_n = ST_UP;
        ST_UP: begin
          if (count == hi_q - ONE) begin
            if (dwell_q != '0) begin
              state_n  = ST_DWELL_HI;
              tmr_load = 1'b1;
            end else begin
              state_n = ST_DOWN;
            end
          end
        end
        ST_DWELL_HI: begin
          if (tmr_expired) state_n = ST_DOWN;
          else             tmr_dec = 1'b1;
        end
        ST_DOWN: begin
          if (count == lo_q + ONE) begin
            if (dwell_q != '0) begin
              state_n  = ST_DWELL_LO;
              tmr_load = 1'b1;
            end else begin
              sweep_end = 1'b1;
            end
          end
        end
        ST_DWELL_LO: begin
          if (tmr_expired) sweep_end = 1'b1;
          else             tmr_dec   = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end

    if (sweep_end) begin
      if (!cont_q && (rem_q == ONE_SW)) begin
        state_n = ST_IDLE;
        park_n  = lo_q;
        done_n  = 1'b1;
      end else begin
        state_n = ST_UP;
        if (!cont_q) rem_n = rem_q - ONE_SW;
      end
    end

    // Outputs are decoded from the next state so they register with it.
    u_d_n  = 1'b1;
    load_n = 1'b1;
    data_n = park_n;
    case (state_n)
      ST_LOAD, ST_DWELL_LO: data_n = lo_n;
      ST_DWELL_HI:          data_n = hi_n;
      ST_UP:                load_n = 1'b0;
      ST_DOWN: begin
        u_d_n  = 1'b0;
        load_n = 1'b0;
      end
      default: ;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      park_q  <= MIN_V;
      lo_q    <= MIN_V;
      hi_q    <= MAX_V;
      dwell_q <= '0;
      rem_q   <= '0;
      cont_q  <= 1'b0;
      exp_q   <= MIN_V;
      u_d     <= 1'b1;
      load    <= 1'b1;
      data    <= MIN_V;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      park_q  <= park_n;
      lo_q    <= lo_n;
      hi_q    <= hi_n;
      dwell_q <= dwell_n;
      rem_q   <= rem_n;
      cont_q  <= cont_n;
      // Expected count follows the controls currently applied to the counter.
      if (load)     exp_q <= data;
      else if (u_d) exp_q <= exp_q + ONE;
      else          exp_q <= exp_q - ONE;
      u_d     <= u_d_n;
      load    <= load_n;
      data    <= data_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule
